// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, transmit FSM state type and the
// reference CRC-32 byte update used by both framer and receive checker.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PAD,
        FCS,
        DROP,
        IFG
    } tx_state_t;

    // Reflected CRC-32 update, data bits consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational next-CRC for one data byte (8 bits per step).
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Pure function of the current CRC and the incoming byte.
    assign crc_next = crc32_byte(crc, data);

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero padding, CRC-32 FCS
// and inter-frame gap. All GMII activity advances on the byte strobe.
//
// Handshake: a byte on tx_tdata is transferred on a clk edge where
// tx_tvalid & tx_tready are both high. tx_tready is combinational and is
// only asserted in DATA/DROP on a byte-strobe cycle; tx_tvalid must be held
// with stable data until accepted. Dropping tx_tvalid inside DATA on a
// strobe cycle is an underrun.
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_PAYLOAD_LENGTH = 46,
    parameter int MAX_PAYLOAD_LENGTH = 1500,
    parameter int HEADER_BYTES       = 14,
    parameter int IFG_BYTES          = 12
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_clk_enable,
    input  logic [7:0] tx_tdata,
    input  logic       tx_tvalid,
    output logic       tx_tready,
    input  logic       tx_tuser,
    input  logic       tx_tlast,
    output logic [7:0] gmii_txd,
    output logic       gmii_txen,
    output logic       gmii_txer,
    output logic       frame_done,
    output logic       frame_error,
    output tx_state_t  fsm_state
);

    localparam logic [10:0] MINB     = 11'(HEADER_BYTES + MIN_PAYLOAD_LENGTH);
    localparam logic [10:0] MAXB     = 11'(HEADER_BYTES + MAX_PAYLOAD_LENGTH);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    tx_state_t   state;
    logic [2:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic [1:0]  fcs_cnt;
    logic [7:0]  ifg_cnt;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [7:0]  crc_data;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;
    logic [10:0] byte_cnt_inc;

    // Pad bytes are zeros; every other CRC byte is the accepted payload byte.
    assign crc_data     = (state == PAD) ? 8'h00 : tx_tdata;
    assign byte_cnt_inc = byte_cnt + 11'd1;
    assign fcs_word     = ~crc;
    assign fsm_state    = state;
    assign tx_tready    = ((state == DATA) || (state == DROP)) && tx_clk_enable;

    eth_crc32_d8 u_crc (
        .crc      (crc),
        .data     (crc_data),
        .crc_next (crc_next)
    );

    // Select the FCS byte being sent, least-significant byte first.
    always_comb begin
        fcs_byte = fcs_word[7:0];
        case (fcs_cnt)
            2'd0: fcs_byte = fcs_word[7:0];
            2'd1: fcs_byte = fcs_word[15:8];
            2'd2: fcs_byte = fcs_word[23:16];
            2'd3: fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    // Framer FSM with registered GMII outputs and one-clk status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pre_cnt     <= 3'd0;
            byte_cnt    <= 11'd0;
            fcs_cnt     <= 2'd0;
            ifg_cnt     <= 8'd0;
            crc         <= CRC_INIT;
            gmii_txd    <= 8'h00;
            gmii_txen   <= 1'b0;
            gmii_txer   <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (tx_clk_enable) begin
                case (state)
                    IDLE: begin
                        gmii_txer <= 1'b0;
                        if (tx_tvalid) begin
                            gmii_txd  <= PREAMBLE_BYTE;
                            gmii_txen <= 1'b1;
                            pre_cnt   <= 3'd1;
                            state     <= PREAMBLE;
                        end else begin
                            gmii_txd  <= 8'h00;
                            gmii_txen <= 1'b0;
                        end
                    end
                    PREAMBLE: begin
                        gmii_txen <= 1'b1;
                        gmii_txer <= 1'b0;
                        if (pre_cnt == 3'd7) begin
                            gmii_txd <= SFD_BYTE;
                            crc      <= CRC_INIT;
                            byte_cnt <= 11'd0;
                            state    <= DATA;
                        end else begin
                            gmii_txd <= PREAMBLE_BYTE;
                            pre_cnt  <= pre_cnt + 3'd1;
                        end
                    end
                    DATA: begin
                        if (tx_tvalid) begin
                            gmii_txd <= tx_tdata;
                            crc      <= crc_next;
                            byte_cnt <= byte_cnt_inc;
                            if (tx_tlast) begin
                                gmii_txer <= tx_tuser;
                                fcs_cnt   <= 2'd0;
                                state     <= (byte_cnt_inc < MINB) ? PAD : FCS;
                            end else if (byte_cnt_inc == MAXB) begin
                                gmii_txer   <= 1'b1;
                                frame_error <= 1'b1;
                                state       <= DROP;
                            end else begin
                                gmii_txer <= tx_tuser;
                            end
                        end else begin
                            gmii_txd    <= 8'h00;
                            gmii_txer   <= 1'b1;
                            frame_error <= 1'b1;
                            state       <= DROP;
                        end
                    end
                    PAD: begin
                        gmii_txd  <= 8'h00;
                        gmii_txer <= 1'b0;
                        crc       <= crc_next;
                        byte_cnt  <= byte_cnt_inc;
                        fcs_cnt   <= 2'd0;
                        if (byte_cnt_inc >= MINB) begin
                            state <= FCS;
                        end
                    end
                    FCS: begin
                        gmii_txd  <= fcs_byte;
                        gmii_txer <= 1'b0;
                        fcs_cnt   <= fcs_cnt + 2'd1;
                        if (fcs_cnt == 2'd3) begin
                            frame_done <= 1'b1;
                            ifg_cnt    <= 8'd0;
                            state      <= IFG;
                        end
                    end
                    DROP: begin
                        gmii_txd  <= 8'h00;
                        gmii_txen <= 1'b1;
                        gmii_txer <= 1'b1;
                        if (tx_tvalid && tx_tlast) begin
                            ifg_cnt <= 8'd0;
                            state   <= IFG;
                        end
                    end
                    IFG: begin
                        gmii_txd  <= 8'h00;
                        gmii_txen <= 1'b0;
                        gmii_txer <= 1'b0;
                        if (ifg_cnt == IFG_LAST) begin
                            state <= IDLE;
                        end else begin
                            ifg_cnt <= ifg_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: default instance plus a
// zero-minimum instance for the CRC known-answer frame.
module tb_gmii_tx_framer;
  import eth_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tuser;
  logic       tx_tlast;
  logic       sel;
  int         ce_div = 1;
  int         ce_cnt = 0;

  logic       m_tready, m_txen, m_txer, m_done, m_err;
  logic [7:0] m_txd;
  tx_state_t  m_state;
  logic       s_tready, s_txen, s_txer, s_done, s_err;
  logic [7:0] s_txd;
  tx_state_t  s_state;

  logic       tready_mon, txen_mon, txer_mon, done_mon, err_mon;
  logic [7:0] txd_mon;

  int tests = 0;
  int fails = 0;

  logic [7:0] frame_data[$];
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  int         hi_q[$];
  int         lo_q[$];
  int         done_cnt, err_cnt, off_ce_cnt, tready_off_cnt, tready_on_cnt;
  int         run = 0;
  logic       prev_txen = 1'b0;
  logic       seen_hi = 1'b0;
  logic [9:0] prev_out = '0;

  gmii_tx_framer dut (
    .clk(clk), .reset(reset), .tx_clk_enable(ce),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid & ~sel), .tx_tready(m_tready),
    .tx_tuser(tx_tuser), .tx_tlast(tx_tlast),
    .gmii_txd(m_txd), .gmii_txen(m_txen), .gmii_txer(m_txer),
    .frame_done(m_done), .frame_error(m_err), .fsm_state(m_state)
  );

  gmii_tx_framer #(.MIN_PAYLOAD_LENGTH(0), .HEADER_BYTES(0)) dut_s (
    .clk(clk), .reset(reset), .tx_clk_enable(ce),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid & sel), .tx_tready(s_tready),
    .tx_tuser(tx_tuser), .tx_tlast(tx_tlast),
    .gmii_txd(s_txd), .gmii_txen(s_txen), .gmii_txer(s_txer),
    .frame_done(s_done), .frame_error(s_err), .fsm_state(s_state)
  );

  assign tready_mon = sel ? s_tready : m_tready;
  assign txen_mon   = sel ? s_txen   : m_txen;
  assign txer_mon   = sel ? s_txer   : m_txer;
  assign txd_mon    = sel ? s_txd    : m_txd;
  assign done_mon   = sel ? s_done   : m_done;
  assign err_mon    = sel ? s_err    : m_err;

  // clock / reset block
  always #5 clk = ~clk;

  // byte strobe: every clk at 1G, 1-in-ce_div otherwise
  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clk);
      if (ce_div <= 1) begin
        ce = 1'b1;
      end else begin
        ce_cnt = (ce_cnt + 1) % ce_div;
        ce = (ce_cnt == 0);
      end
    end
  end

  // output monitor, sampled 1 unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (txen_mon && ce) cap_q.push_back({txer_mon, txd_mon});
    if (done_mon) done_cnt++;
    if (err_mon) err_cnt++;
    if (!ce && ({txen_mon, txer_mon, txd_mon} != prev_out)) off_ce_cnt++;
    prev_out = {txen_mon, txer_mon, txd_mon};
    if (txen_mon !== prev_txen) begin
      if (prev_txen) hi_q.push_back(run);
      else if (seen_hi) lo_q.push_back(run);
      if (txen_mon) seen_hi = 1'b1;
      run = 1;
      prev_txen = txen_mon;
    end else begin
      run++;
    end
  end

  // tready must only rise on strobe cycles
  always @(negedge clk) begin
    #2;
    if (tready_mon && !ce) tready_off_cnt++;
    if (tready_mon && ce) tready_on_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
    return c;
  endfunction

  task automatic clear_mon();
    cap_q.delete(); exp_q.delete(); hi_q.delete(); lo_q.delete();
    done_cnt = 0; err_cnt = 0; off_ce_cnt = 0;
    tready_off_cnt = 0; tready_on_cnt = 0; seen_hi = 1'b0;
  endtask

  task automatic load_ramp(input int len, input int start);
    frame_data.delete();
    for (int k = 0; k < len; k++) frame_data.push_back(8'(start + k));
  endtask

  task automatic load_ascii();
    frame_data.delete();
    for (int k = 0; k < 9; k++) frame_data.push_back(8'(8'h31 + k));
  endtask

  task automatic exp_preamble();
    for (int k = 0; k < 7; k++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
  endtask

  // expected normal frame: preamble, payload, zero pad to minb, ~CRC LSB first
  task automatic exp_normal(input int minb, input int tuser_at);
    logic [31:0] c;
    exp_preamble();
    c = 32'hFFFFFFFF;
    for (int k = 0; k < frame_data.size(); k++) begin
      exp_q.push_back({(k == tuser_at), frame_data[k]});
      c = crc_step(c, frame_data[k]);
    end
    for (int k = frame_data.size(); k < minb; k++) begin
      exp_q.push_back(9'h000);
      c = crc_step(c, 8'h00);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
  endtask

  // driver: one beat per accepted handshake, optional underrun / reset abort
  task automatic send_frame(input int underrun_at, input int reset_at, input int tuser_at);
    int  i;
    int  guard;
    bit  acc;
    bit  und_done;
    i = 0; guard = 0; und_done = 0;
    while (i < frame_data.size()) begin
      @(negedge clk);
      if (i == reset_at) begin
        reset = 1'b1; tx_tvalid = 1'b0; tx_tlast = 1'b0; tx_tuser = 1'b0;
        #1;
        check("reset_mid_txen", 32'(txen_mon), 32'd0);
        check("reset_mid_tready", 32'(tready_mon), 32'd0);
        check("reset_mid_state", 32'(m_state), 32'(IDLE));
        @(posedge clk); #1;
        check("reset_mid_txen_clk", 32'(txen_mon), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (i == underrun_at && !und_done) begin
        und_done = 1;
        tx_tvalid = 1'b0; tx_tlast = 1'b0;
        @(posedge clk);
        continue;
      end
      tx_tvalid = 1'b1;
      tx_tdata  = frame_data[i];
      tx_tlast  = (i == frame_data.size() - 1);
      tx_tuser  = (i == tuser_at);
      #1;
      acc = tready_mon;
      @(posedge clk);
      if (acc) begin
        i++; guard = 0;
      end else begin
        guard++;
        if (guard > 2000) begin
          check("send_timeout", 32'(i), 32'(frame_data.size()));
          break;
        end
      end
    end
    @(negedge clk);
    tx_tvalid = 1'b0; tx_tlast = 1'b0; tx_tuser = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while (n < 20000) begin
      @(posedge clk); #2;
      if (!txen_mon) break;
      n++;
    end
    check({tag, "_quiet_timeout"}, 32'(n < 20000), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      check($sformatf("%s_byte%0d", tag, k), 32'(cap_q[k]), 32'(exp_q[k]));
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0;
    tx_tdata = 8'h00; tx_tvalid = 1'b0; tx_tuser = 1'b0; tx_tlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_txd", 32'(m_txd), 32'h00);
    check("rst_txen", 32'(m_txen), 32'd0);
    check("rst_txer", 32'(m_txer), 32'd0);
    check("rst_tready", 32'(m_tready), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_error", 32'(m_err), 32'd0);
    check("rst_state", 32'(m_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1G: min frame then 9-byte frame padded to 60, back to back
    clear_mon();
    load_ramp(60, 0);
    exp_normal(60, -1);
    send_frame(-1, -1, -1);
    load_ascii();
    exp_normal(60, -1);
    send_frame(-1, -1, -1);
    wait_quiet("g1");
    compare_stream("g1");
    check("g1_hi_runs", 32'(hi_q.size()), 32'd2);
    if (hi_q.size() >= 2) begin
      check("g1_txen_len0", 32'(hi_q[0]), 32'd72);
      check("g1_txen_len1", 32'(hi_q[1]), 32'd72);
    end
    check("g1_lo_runs", 32'(lo_q.size()), 32'd1);
    if (lo_q.size() >= 1) check("g1_ifg", 32'(lo_q[0]), 32'd12);
    check("g1_done", 32'(done_cnt), 32'd2);
    check("g1_error", 32'(err_cnt), 32'd0);

    // zero-minimum instance: "123456789" known-answer FCS
    repeat (20) @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    clear_mon();
    load_ascii();
    exp_preamble();
    for (int k = 0; k < 9; k++) exp_q.push_back({1'b0, frame_data[k]});
    exp_q.push_back({1'b0, 8'h26});
    exp_q.push_back({1'b0, 8'h39});
    exp_q.push_back({1'b0, 8'hF4});
    exp_q.push_back({1'b0, 8'hCB});
    send_frame(-1, -1, -1);
    wait_quiet("kat");
    compare_stream("kat");
    check("kat_done", 32'(done_cnt), 32'd1);
    repeat (20) @(negedge clk);
    sel = 1'b0;

    // 100M: two 64-byte frames, second carries one tuser-marked byte
    ce_div = 10;
    repeat (30) @(negedge clk);
    clear_mon();
    load_ramp(64, 8'h40);
    exp_normal(60, -1);
    send_frame(-1, -1, -1);
    load_ramp(64, 8'h80);
    exp_normal(60, 10);
    send_frame(-1, -1, 10);
    wait_quiet("m100");
    compare_stream("m100");
    check("m100_hi_runs", 32'(hi_q.size()), 32'd2);
    if (hi_q.size() >= 2) begin
      check("m100_txen_len0", 32'(hi_q[0]), 32'd760);
      check("m100_txen_len1", 32'(hi_q[1]), 32'd760);
    end
    check("m100_lo_runs", 32'(lo_q.size()), 32'd1);
    if (lo_q.size() >= 1) check("m100_ifg", 32'(lo_q[0]), 32'd120);
    check("m100_off_ce_change", 32'(off_ce_cnt), 32'd0);
    check("m100_tready_off_ce", 32'(tready_off_cnt), 32'd0);
    check("m100_tready_on_ce", 32'(tready_on_cnt), 32'd128);
    check("m100_done", 32'(done_cnt), 32'd2);
    ce_div = 1;
    repeat (150) @(negedge clk);

    // underrun at data byte 20
    clear_mon();
    load_ramp(60, 8'h10);
    exp_preamble();
    for (int k = 0; k < 19; k++) exp_q.push_back({1'b0, frame_data[k]});
    for (int k = 0; k < 42; k++) exp_q.push_back({1'b1, 8'h00});
    send_frame(19, -1, -1);
    wait_quiet("und");
    compare_stream("und");
    check("und_error", 32'(err_cnt), 32'd1);
    check("und_done", 32'(done_cnt), 32'd0);
    repeat (20) @(negedge clk);

    // oversize 1600-byte frame
    clear_mon();
    load_ramp(1600, 0);
    exp_preamble();
    for (int k = 0; k < 1513; k++) exp_q.push_back({1'b0, frame_data[k]});
    exp_q.push_back({1'b1, frame_data[1513]});
    for (int k = 0; k < 86; k++) exp_q.push_back({1'b1, 8'h00});
    send_frame(-1, -1, -1);
    wait_quiet("ovr");
    compare_stream("ovr");
    check("ovr_error", 32'(err_cnt), 32'd1);
    check("ovr_done", 32'(done_cnt), 32'd0);
    repeat (20) @(negedge clk);

    // reset at data byte 30, then a clean 60-byte frame
    clear_mon();
    load_ramp(60, 8'h20);
    send_frame(-1, 30, -1);
    repeat (3) @(negedge clk);
    clear_mon();
    load_ramp(60, 8'hC0);
    exp_normal(60, -1);
    send_frame(-1, -1, -1);
    wait_quiet("rst");
    compare_stream("rst");
    check("rst_frame_done", 32'(done_cnt), 32'd1);
    check("rst_frame_error", 32'(err_cnt), 32'd0);
    if (hi_q.size() >= 1) check("rst_txen_len", 32'(hi_q[0]), 32'd72);
    else check("rst_hi_runs", 32'(hi_q.size()), 32'd1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
